uart_intr_ctrl: RTL and testbench

UART_INTR_CTRL -- requirements
Module: uart_intr_ctrl

---
 rtl/uart_intr_pkg.sv | 42 ++++
 rtl/uart_intr_src.sv | 40 ++++
 rtl/uart_intr_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_intr_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_intr_pkg.sv
// Purpose: shared register map, source indices and FSM encoding for the UART interrupt controller.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package uart_intr_pkg;

   // Register byte addresses
   localparam logic [11:0] ADDR_STATE   = 12'h040;
   localparam logic [11:0] ADDR_ENABLE  = 12'h044;
   localparam logic [11:0] ADDR_TEST    = 12'h048;
   localparam logic [11:0] ADDR_MODE    = 12'h04C;
   localparam logic [11:0] ADDR_HOLDOFF = 12'h050;
   localparam logic [11:0] ADDR_RAW     = 12'h054;
   localparam logic [11:0] ADDR_ID      = 12'h058;

   // Interrupt source bit positions
   localparam int SRC_TX         = 0;
   localparam int SRC_RX         = 1;
   localparam int SRC_TX_LEVEL   = 2;
   localparam int SRC_RX_TIMEOUT = 3;
   localparam int SRC_TX_FULL    = 4;
   localparam int SRC_TX_EMPTY   = 5;
   localparam int SRC_RX_FULL    = 6;
   localparam int SRC_RX_EMPTY   = 7;
   localparam int NUM_SRC        = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } fsm_state_e;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] vec);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (vec[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/uart_intr_src.sv
// Purpose: one interrupt source bit: input sampling, level/edge detect, sticky W1C status.
// Latency: status bit sets on the clock edge that samples the qualifying input.
// Backpressure: none; a set arriving with a clear of the same bit wins.
module uart_intr_src
   import uart_intr_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic src_i,
   input  logic mode_i,
   input  logic test_i,
   input  logic clr_i,
   output logic state_o,
   output logic raw_o
);

   logic src_q;
   logic state_q;
   logic state_d;
   logic set;

   // Edge mode needs a fresh 0->1 against the previous sample; level mode sets while high.
   assign set     = (mode_i & src_i & ~src_q) | (~mode_i & src_i) | test_i;
   assign state_d = set | (state_q & ~clr_i);

   // Source sample and sticky status register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         src_q   <= 1'b0;
         state_q <= 1'b0;
      end else begin
         src_q   <= src_i;
         state_q <= state_d;
      end
   end

   assign state_o = state_q;
   assign raw_o   = src_q;

endmodule

// File: rtl/uart_intr_ctrl.sv
// Purpose: UART interrupt controller: register block, 8 sticky sources, irq FSM with holdoff.
// Latency: irq_o rises 2 cycles after a source edge; register reads return 1 cycle after reg_re.
// Backpressure: none; every access completes in one cycle, unmapped ones pulse reg_err_o.
module uart_intr_ctrl
   import uart_intr_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] reg_wdata,
   input  logic [11:0] reg_addr,
   input  logic        reg_we,
   input  logic        reg_re,
   input  logic [7:0]  intr_src_i,
   output logic [31:0] reg_rdata,
   output logic        reg_err_o,
   output logic        irq_o,
   output logic [2:0]  irq_id_o
);

   logic [7:0]  enable_q;
   logic [7:0]  mode_q;
   logic [15:0] holdoff_q;
   logic [7:0]  state_vec;
   logic [7:0]  raw_vec;
   logic [7:0]  pending;
   logic        id_vld;
   logic [2:0]  id_idx;
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;
   logic        err_q;
   logic        irq_q;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   fsm_state_e  fsm_q;
   fsm_state_e  fsm_d;

   logic hit_state, hit_enable, hit_test, hit_mode, hit_holdoff, hit_raw, hit_id, mapped;
   logic [7:0] test_set;
   logic [7:0] w1c_clr;
   logic       unused_wdata;

   assign unused_wdata = ^reg_wdata[31:16];

   assign hit_state   = (reg_addr == ADDR_STATE);
   assign hit_enable  = (reg_addr == ADDR_ENABLE);
   assign hit_test    = (reg_addr == ADDR_TEST);
   assign hit_mode    = (reg_addr == ADDR_MODE);
   assign hit_holdoff = (reg_addr == ADDR_HOLDOFF);
   assign hit_raw     = (reg_addr == ADDR_RAW);
   assign hit_id      = (reg_addr == ADDR_ID);
   assign mapped      = hit_state | hit_enable | hit_test | hit_mode |
                        hit_holdoff | hit_raw | hit_id;

   assign test_set = (reg_we && hit_test)  ? reg_wdata[7:0] : 8'h00;
   assign w1c_clr  = (reg_we && hit_state) ? reg_wdata[7:0] : 8'h00;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      uart_intr_src u_src (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .src_i   (intr_src_i[g]),
         .mode_i  (mode_q[g]),
         .test_i  (test_set[g]),
         .clr_i   (w1c_clr[g]),
         .state_o (state_vec[g]),
         .raw_o   (raw_vec[g])
      );
   end

   // ENABLE only gates the output side; STATE keeps latching regardless.
   assign pending  = state_vec & enable_q;
   assign id_vld   = |pending;
   assign id_idx   = id_vld ? lowest_idx(pending) : 3'd0;
   assign irq_id_o = id_idx;

   // Writable configuration registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         enable_q  <= 8'h00;
         mode_q    <= 8'h00;
         holdoff_q <= 16'h0000;
      end else if (reg_we) begin
         if (hit_enable)  enable_q  <= reg_wdata[7:0];
         if (hit_mode)    mode_q    <= reg_wdata[7:0];
         if (hit_holdoff) holdoff_q <= reg_wdata[15:0];
      end
   end

   // Read mux; TEST and unmapped addresses return zero
   always_comb begin
      rdata_d = 32'h0;
      case (1'b1)
         hit_state:   rdata_d = {24'h0, state_vec};
         hit_enable:  rdata_d = {24'h0, enable_q};
         hit_mode:    rdata_d = {24'h0, mode_q};
         hit_holdoff: rdata_d = {16'h0, holdoff_q};
         hit_raw:     rdata_d = {24'h0, raw_vec};
         hit_id:      rdata_d = {23'h0, id_vld, 5'h0, id_idx};
         default:     rdata_d = 32'h0;
      endcase
   end

   // Registered read data (write wins over a simultaneous read) and error pulse
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         if (reg_re && !reg_we) rdata_q <= rdata_d;
         err_q <= (reg_we | reg_re) & ~mapped;
      end
   end

   assign reg_rdata = rdata_q;
   assign reg_err_o = err_q;

   // FSM state, holdoff counter and registered irq
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsm_q <= ST_IDLE;
         cnt_q <= 16'h0;
         irq_q <= 1'b0;
      end else begin
         fsm_q <= fsm_d;
         cnt_q <= cnt_d;
         irq_q <= (fsm_d == ST_ASSERT);
      end
   end

   // Next-state: the last holdoff cycle hands straight to ASSERT when something
   // is pending, so irq_o stays low for exactly HOLDOFF cycles rather than one more.
   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      case (fsm_q)
         ST_IDLE: begin
            if (id_vld) fsm_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (!id_vld) begin
               if (holdoff_q == 16'h0) begin
                  fsm_d = ST_IDLE;
               end else begin
                  fsm_d = ST_HOLDOFF;
                  cnt_d = holdoff_q;
               end
            end
         end
         ST_HOLDOFF: begin
            if (cnt_q != 16'h0) cnt_d = cnt_q - 16'h1;
            if (cnt_q <= 16'h1) fsm_d = id_vld ? ST_ASSERT : ST_IDLE;
         end
         default: begin
            fsm_d = ST_IDLE;
            cnt_d = 16'h0;
         end
      endcase
   end

   assign irq_o = irq_q;

endmodule

// File: tb/tb_uart_intr_ctrl.sv
// Purpose: directed self-checking bench for uart_intr_ctrl.
// Latency: checks sampled 1 time unit after each rising clock edge.
// Backpressure: n/a; stimulus is a fixed linear sequence.
module tb_uart_intr_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] reg_wdata;
   logic [11:0] reg_addr;
   logic        reg_we;
   logic        reg_re;
   logic [7:0]  intr_src_i;
   logic [31:0] reg_rdata;
   logic        reg_err_o;
   logic        irq_o;
   logic [2:0]  irq_id_o;

   int n_tests = 0;
   int n_fail  = 0;

   uart_intr_ctrl dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .reg_wdata  (reg_wdata),
      .reg_addr   (reg_addr),
      .reg_we     (reg_we),
      .reg_re     (reg_re),
      .intr_src_i (intr_src_i),
      .reg_rdata  (reg_rdata),
      .reg_err_o  (reg_err_o),
      .irq_o      (irq_o),
      .irq_id_o   (irq_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      reg_addr  = a;
      reg_wdata = d;
      reg_we    = 1'b1;
      tick();
      reg_we    = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      reg_addr = a;
      reg_re   = 1'b1;
      tick();
      reg_re   = 1'b0;
      d        = reg_rdata;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      rst_i = 1'b1; reg_wdata = '0; reg_addr = '0; reg_we = 1'b0; reg_re = 1'b0; intr_src_i = '0;
      tick(); tick();
      check("rst_irq",   {31'h0, irq_o},     32'h0);
      check("rst_rdata", reg_rdata,          32'h0);
      check("rst_err",   {31'h0, reg_err_o}, 32'h0);
      check("rst_id",    {29'h0, irq_id_o},  32'h0);
      rst_i = 1'b0;
      tick();
      rd(12'h040, d); check("rst_state", d, 32'h0);

      // rx_full in level mode
      wr(12'h044, 32'h40);
      intr_src_i = 8'h40;
      tick();
      check("lvl_irq_1cyc", {31'h0, irq_o}, 32'h0);
      tick();
      check("lvl_irq_2cyc", {31'h0, irq_o}, 32'h1);
      check("lvl_id",       {29'h0, irq_id_o}, 32'h6);
      rd(12'h040, d); check("lvl_state", d, 32'h40);
      wr(12'h040, 32'h40);
      rd(12'h040, d); check("lvl_w1c_reset", d, 32'h40);
      intr_src_i = 8'h00;
      wr(12'h040, 32'h40);
      rd(12'h040, d); check("lvl_w1c_clear", d, 32'h0);
      check("lvl_irq_drop", {31'h0, irq_o}, 32'h0);
      wr(12'h044, 32'h00);

      // tx in edge mode, held high 5 cycles, cleared on cycle 3
      wr(12'h04C, 32'h01);
      intr_src_i = 8'h01;
      tick();
      rd(12'h040, d); check("edge_set_once", d, 32'h01);
      wr(12'h040, 32'h01);
      tick();
      rd(12'h040, d); check("edge_stay_clr", d, 32'h00);
      intr_src_i = 8'h00;

      // rx_timeout edge colliding with its W1C
      wr(12'h04C, 32'h09);
      intr_src_i = 8'h08;
      tick();
      intr_src_i = 8'h00;
      tick();
      rd(12'h040, d); check("coll_pre", d, 32'h08);
      intr_src_i = 8'h08;
      wr(12'h040, 32'h08);
      intr_src_i = 8'h00;
      rd(12'h040, d); check("coll_set_wins", d, 32'h08);
      wr(12'h040, 32'h08);
      rd(12'h040, d); check("coll_clr", d, 32'h00);

      // holdoff of 4 cycles with a new event and a HOLDOFF rewrite during countdown
      wr(12'h04C, 32'h00);
      wr(12'h044, 32'h02);
      wr(12'h050, 32'h4);
      wr(12'h048, 32'h02);
      tick();
      check("ho_irq_on", {31'h0, irq_o}, 32'h1);
      wr(12'h040, 32'h02);
      check("ho_irq_still", {31'h0, irq_o}, 32'h1);
      tick();
      check("ho_low1", {31'h0, irq_o}, 32'h0);
      wr(12'h048, 32'h02);
      check("ho_low2", {31'h0, irq_o}, 32'h0);
      wr(12'h050, 32'd100);
      check("ho_low3", {31'h0, irq_o}, 32'h0);
      tick();
      check("ho_low4", {31'h0, irq_o}, 32'h0);
      tick();
      check("ho_reassert5", {31'h0, irq_o}, 32'h1);
      rd(12'h050, d); check("ho_reg_rd", d, 32'd100);

      // reset in the middle of a 100-cycle holdoff
      wr(12'h040, 32'h02);
      tick();
      check("rho_low", {31'h0, irq_o}, 32'h0);
      wr(12'h048, 32'h01);
      tick();
      rst_i = 1'b1;
      #1;
      check("rho_irq", {31'h0, irq_o}, 32'h0);
      tick();
      rst_i = 1'b0;
      tick();
      rd(12'h040, d); check("rho_state",   d, 32'h0);
      rd(12'h050, d); check("rho_holdoff", d, 32'h0);
      rd(12'h044, d); check("rho_enable",  d, 32'h0);
      wr(12'h044, 32'h20);
      wr(12'h048, 32'h20);
      check("rho_idle_wait", {31'h0, irq_o}, 32'h0);
      tick();
      check("rho_idle_fire", {31'h0, irq_o}, 32'h1);

      // TEST write, ID read, unmapped accesses, simultaneous we/re
      wr(12'h048, 32'hA0);
      rd(12'h040, d); check("tst_state", d, 32'hA0);
      rd(12'h058, d); check("tst_id", d, 32'h105);
      check("tst_irq_id", {29'h0, irq_id_o}, 32'h5);
      rd(12'h0FC, d); check("unm_rd_data", d, 32'h0);
      check("unm_rd_err", {31'h0, reg_err_o}, 32'h1);
      tick();
      check("unm_err_1cyc", {31'h0, reg_err_o}, 32'h0);
      wr(12'h0FC, 32'hFF);
      check("unm_wr_err", {31'h0, reg_err_o}, 32'h1);
      rd(12'h044, d); check("unm_wr_noeff", d, 32'h20);
      reg_addr = 12'h044; reg_wdata = 32'h60; reg_we = 1'b1; reg_re = 1'b1;
      tick();
      reg_we = 1'b0; reg_re = 1'b0;
      check("were_rdata_hold", reg_rdata, 32'h20);
      rd(12'h044, d); check("were_write", d, 32'h60);
      rd(12'h048, d); check("test_reads0", d, 32'h0);

      // reset while irq is asserted, with a level source held through reset
      check("ra_irq_pre", {31'h0, irq_o}, 32'h1);
      intr_src_i = 8'h40;
      rst_i = 1'b1;
      #1;
      check("ra_irq_drop", {31'h0, irq_o}, 32'h0);
      check("ra_rdata",    reg_rdata,      32'h0);
      tick();
      rst_i = 1'b0;
      tick();
      rd(12'h040, d); check("ra_lvl_first_edge", d, 32'h40);
      rd(12'h054, d); check("raw_reg", d, 32'h40);
      intr_src_i = 8'h00;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
